mkt_msg_parser_v2: RTL and testbench

Parametrised successor to the fixed 16-byte market-data byte parser. Accepts a byte stream with valid/ready and start-of-message marking, and extracts msg_type, stock_id, order_id, price, quantity and padding at configurable widths and byte order. Presents each completed message on a one-entry valid/ready output slot, so the next message can be collected while the previous one waits. Keeps message and error statistics, and sits between the feed deframer and the order-book update logic.

---
 rtl/mkt_msg_parser_v2.sv | 238 +++++++++++++++++++++++
 tb/tb_mkt_msg_parser_v2.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/mkt_msg_parser_v2.sv
// mkt_msg_parser_v2 -- market-data message byte parser.
//
// Collects a byte stream (valid/ready, start-of-message marked) into fixed
// length messages and splits each one into msg_type, stock_id, order_id,
// price, quantity and padding. Field widths and byte order are parameters.
// A finished message is copied into a one-entry output slot, so the next
// message can be collected while the consumer is still busy with this one.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid/in_ready     input byte handshake
//   in_sop, byte_in       start-of-message flag and data byte
//   out_valid/out_ready   output slot handshake
//   msg_type .. padding   fields of the message held in the slot
//   msg_count             messages delivered (saturating)
//   err_count             messages aborted by an early sop (saturating)
//   drop_count            bytes discarded while hunting for sop (saturating)
module mkt_msg_parser_v2 #(
  parameter int STOCK_BYTES = 1,
  parameter int ORDER_BYTES = 4,
  parameter int PRICE_BYTES = 4,
  parameter int QTY_BYTES   = 4,
  parameter int MSG_BYTES   = 16,
  parameter int BIG_ENDIAN  = 1,
  parameter int CNT_W       = 16,
  localparam int PAD_BYTES  = MSG_BYTES - 1 - STOCK_BYTES - ORDER_BYTES - PRICE_BYTES - QTY_BYTES,
  localparam int PAD_W      = (PAD_BYTES == 0) ? 1 : 8 * PAD_BYTES
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sop,
  input  logic [7:0]               byte_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               msg_type,
  output logic [8*STOCK_BYTES-1:0] stock_id,
  output logic [8*ORDER_BYTES-1:0] order_id,
  output logic [8*PRICE_BYTES-1:0] price,
  output logic [8*QTY_BYTES-1:0]   quantity,
  output logic [PAD_W-1:0]         padding,
  output logic [CNT_W-1:0]         msg_count,
  output logic [CNT_W-1:0]         err_count,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int MSG_W     = 8 * MSG_BYTES;
  localparam int IDX_W     = $clog2(MSG_BYTES);
  localparam int STOCK_W   = 8 * STOCK_BYTES;
  localparam int ORDER_W   = 8 * ORDER_BYTES;
  localparam int PRICE_W   = 8 * PRICE_BYTES;
  localparam int QTY_W     = 8 * QTY_BYTES;
  localparam int OFF_STOCK = 1;
  localparam int OFF_ORDER = OFF_STOCK + STOCK_BYTES;
  localparam int OFF_PRICE = OFF_ORDER + ORDER_BYTES;
  localparam int OFF_QTY   = OFF_PRICE + PRICE_BYTES;
  localparam int OFF_PAD   = OFF_QTY + QTY_BYTES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Pull an nb-byte field starting at byte offset off out of the shadow
  // buffer (byte i of the message lives in bits [8i+7:8i]). Big-endian
  // shifts each byte in at the LSB, so the first byte ends up as the MSB.
  function automatic logic [63:0] get_field(input logic [MSG_W-1:0] b,
                                            input int off, input int nb);
    logic [63:0] sh;
    logic [63:0] f;
    sh = 64'(b >> (off * 8));
    f  = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < nb) begin
        if (BIG_ENDIAN != 0) f = {f[55:0], sh[k*8 +: 8]};
        else                 f[k*8 +: 8] = sh[k*8 +: 8];
      end
    end
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MSG_W-1:0]   buf_q, buf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         type_q, type_d;
  logic [STOCK_W-1:0] stock_q, stock_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [PAD_W-1:0]   pad_q, pad_d;
  logic [CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic acc;
  logic hs;
  logic slot_free;
  logic load;

  assign acc       = in_valid & in_ready_q;
  assign hs        = out_valid_q & out_ready;
  // Slot is usable if empty, or if its current content leaves this cycle.
  assign slot_free = ~out_valid_q | hs;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    type_d      = type_q;
    stock_d     = stock_q;
    order_d     = order_q;
    price_d     = price_q;
    qty_d       = qty_q;
    pad_d       = pad_q;
    err_cnt_d   = err_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    load        = 1'b0;
    out_valid_d = out_valid_q & ~hs;
    msg_cnt_d   = hs ? sat_inc(msg_cnt_q) : msg_cnt_q;

    case (state_q)
      HUNT: begin
        if (acc) begin
          if (in_sop) begin
            buf_d       = '0;
            buf_d[7:0]  = byte_in;
            idx_d       = IDX_W'(1);
            state_d     = COLLECT;
          end else begin
            drop_cnt_d  = sat_inc(drop_cnt_q);
          end
        end
      end
      COLLECT: begin
        if (acc) begin
          if (in_sop) begin
            // Early sop: abandon the partial message, restart with this byte.
            err_cnt_d  = sat_inc(err_cnt_q);
            buf_d      = '0;
            buf_d[7:0] = byte_in;
            idx_d      = IDX_W'(1);
          end else begin
            for (int i = 0; i < MSG_BYTES; i++) begin
              if (idx_q == IDX_W'(i)) buf_d[i*8 +: 8] = byte_in;
            end
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              if (slot_free) begin
                load    = 1'b1;
                state_d = HUNT;
              end else begin
                state_d = HOLD;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end
      HOLD: begin
        if (hs) begin
          load    = 1'b1;
          state_d = HUNT;
        end
      end
      default: state_d = HUNT;
    endcase

    // Copy from buf_d so the final byte of the message is included.
    if (load) begin
      out_valid_d = 1'b1;
      type_d      = buf_d[7:0];
      stock_d     = STOCK_W'(get_field(buf_d, OFF_STOCK, STOCK_BYTES));
      order_d     = ORDER_W'(get_field(buf_d, OFF_ORDER, ORDER_BYTES));
      price_d     = PRICE_W'(get_field(buf_d, OFF_PRICE, PRICE_BYTES));
      qty_d       = QTY_W'(get_field(buf_d, OFF_QTY, QTY_BYTES));
      pad_d       = (PAD_BYTES > 0) ? PAD_W'(get_field(buf_d, OFF_PAD, PAD_BYTES)) : '0;
    end

    in_ready_d = (state_d != HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      buf_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      type_q      <= '0;
      stock_q     <= '0;
      order_q     <= '0;
      price_q     <= '0;
      qty_q       <= '0;
      pad_q       <= '0;
      msg_cnt_q   <= '0;
      err_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      type_q      <= type_d;
      stock_q     <= stock_d;
      order_q     <= order_d;
      price_q     <= price_d;
      qty_q       <= qty_d;
      pad_q       <= pad_d;
      msg_cnt_q   <= msg_cnt_d;
      err_cnt_q   <= err_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign msg_type   = type_q;
  assign stock_id   = stock_q;
  assign order_id   = order_q;
  assign price      = price_q;
  assign quantity   = qty_q;
  assign padding    = pad_q;
  assign msg_count  = msg_cnt_q;
  assign err_count  = err_cnt_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_mkt_msg_parser_v2.sv
module tb_mkt_msg_parser_v2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the big-endian and little-endian default instances
  logic        reset_n, in_valid, in_sop, out_ready;
  logic [7:0]  byte_in;

  logic        be_in_ready, be_out_valid;
  logic [7:0]  be_type, be_stock;
  logic [31:0] be_order, be_price, be_qty;
  logic [15:0] be_pad, be_msg, be_err, be_drop;

  logic        le_in_ready, le_out_valid;
  logic [7:0]  le_type, le_stock;
  logic [31:0] le_order, le_price, le_qty;
  logic [15:0] le_pad, le_msg, le_err, le_drop;

  // Wide-field instance
  logic        w_reset_n, w_in_valid, w_in_sop, w_out_ready;
  logic [7:0]  w_byte_in;
  logic        w_in_ready, w_out_valid;
  logic [7:0]  w_type;
  logic [15:0] w_stock;
  logic [63:0] w_order;
  logic [31:0] w_price, w_qty;
  logic [39:0] w_pad;
  logic [15:0] w_msg, w_err, w_drop;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] M1 = 128'h41_07_01020304_00002710_00000064_0000;
  localparam logic [127:0] M2 = 128'h42_09_00000005_00000064_0000000A_1234;
  localparam logic [191:0] MW = 192'hA5_1234_0123456789ABCDEF_000003E8_0000002A_1122334455;

  mkt_msg_parser_v2 u_be (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(be_in_ready),
    .in_sop(in_sop), .byte_in(byte_in), .out_valid(be_out_valid), .out_ready(out_ready),
    .msg_type(be_type), .stock_id(be_stock), .order_id(be_order), .price(be_price),
    .quantity(be_qty), .padding(be_pad), .msg_count(be_msg), .err_count(be_err),
    .drop_count(be_drop)
  );

  mkt_msg_parser_v2 #(.BIG_ENDIAN(0)) u_le (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(le_in_ready),
    .in_sop(in_sop), .byte_in(byte_in), .out_valid(le_out_valid), .out_ready(out_ready),
    .msg_type(le_type), .stock_id(le_stock), .order_id(le_order), .price(le_price),
    .quantity(le_qty), .padding(le_pad), .msg_count(le_msg), .err_count(le_err),
    .drop_count(le_drop)
  );

  mkt_msg_parser_v2 #(.STOCK_BYTES(2), .ORDER_BYTES(8), .MSG_BYTES(24)) u_wide (
    .clk(clk), .reset_n(w_reset_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_sop(w_in_sop), .byte_in(w_byte_in), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .msg_type(w_type), .stock_id(w_stock), .order_id(w_order), .price(w_price),
    .quantity(w_qty), .padding(w_pad), .msg_count(w_msg), .err_count(w_err),
    .drop_count(w_drop)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic sop, input logic [7:0] b);
    in_valid = 1'b1; in_sop = sop; byte_in = b;
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0;
  endtask

  task automatic send_msg(input logic [127:0] m);
    for (int i = 0; i < 16; i++) send_byte(i == 0, m[127-8*i -: 8]);
  endtask

  task automatic send_w(input logic [191:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      w_in_valid = 1'b1; w_in_sop = (i == 0); w_byte_in = m[191-8*i -: 8];
      @(negedge clk);
      w_in_valid = 1'b0; w_in_sop = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_sop = 1'b0; byte_in = '0; out_ready = 1'b0;
    w_reset_n = 1'b0; w_in_valid = 1'b0; w_in_sop = 1'b0; w_byte_in = '0; w_out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready", be_in_ready, 0);
    check("rst_out_valid", be_out_valid, 0);
    check("rst_msg_count", be_msg, 0);
    check("rst_order", be_order, 0);
    reset_n = 1'b1; w_reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", be_in_ready, 1);

    // Basic message, both byte orders
    out_ready = 1'b1;
    send_msg(M1);
    check("m1_out_valid", be_out_valid, 1);
    check("m1_type", be_type, 64'h41);
    check("m1_stock", be_stock, 64'h07);
    check("m1_order", be_order, 64'h01020304);
    check("m1_price", be_price, 64'h00002710);
    check("m1_qty", be_qty, 64'h00000064);
    check("m1_pad", be_pad, 64'h0);
    check("m1_cnt_before_hs", be_msg, 0);
    check("m1_le_order", le_order, 64'h04030201);
    check("m1_le_price", le_price, 64'h10270000);
    check("m1_le_qty", le_qty, 64'h64000000);
    @(negedge clk);
    check("m1_msg_count", be_msg, 1);
    check("m1_valid_drop", be_out_valid, 0);

    // Back-pressure: two messages back-to-back with the consumer stalled
    out_ready = 1'b0;
    send_msg(M1);
    send_msg(M2);
    check("bp_in_ready_low", be_in_ready, 0);
    check("bp_valid", be_out_valid, 1);
    check("bp_type_held", be_type, 64'h41);
    repeat (2) @(negedge clk);
    check("bp_order_stable", be_order, 64'h01020304);
    check("bp_valid_stable", be_out_valid, 1);
    check("bp_in_ready_still_low", be_in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_handoff_valid", be_out_valid, 1);
    check("bp_m2_type", be_type, 64'h42);
    check("bp_m2_order", be_order, 64'h00000005);
    check("bp_m2_qty", be_qty, 64'h0000000A);
    check("bp_m2_pad", be_pad, 64'h1234);
    check("bp_m2_le_order", le_order, 64'h05000000);
    check("bp_m2_le_pad", le_pad, 64'h3412);
    check("bp_in_ready_back", be_in_ready, 1);
    check("bp_msg_count", be_msg, 2);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_msg_count2", be_msg, 3);
    check("bp_valid_off", be_out_valid, 0);

    // Truncated message followed by a complete one
    send_byte(1'b1, 8'h41);
    for (int i = 0; i < 5; i++) send_byte(1'b0, 8'hEE);
    send_msg(M2);
    check("tr_err_count", be_err, 1);
    check("tr_valid", be_out_valid, 1);
    check("tr_type", be_type, 64'h42);
    check("tr_price", be_price, 64'h00000064);
    @(negedge clk);
    check("tr_msg_count", be_msg, 4);
    check("tr_le_err", le_err, 1);

    // Hunt: bytes without sop are dropped
    for (int i = 0; i < 3; i++) send_byte(1'b0, 8'h55);
    check("hunt_drop_count", be_drop, 3);
    check("hunt_no_valid", be_out_valid, 0);
    send_msg(M1);
    check("hunt_type", be_type, 64'h41);
    @(negedge clk);
    check("hunt_msg_count", be_msg, 5);
    check("hunt_drop_final", be_drop, 3);

    // Wide fields, then reset in the middle of a message
    w_out_ready = 1'b0;
    send_w(MW, 24);
    check("w_valid", w_out_valid, 1);
    check("w_type", w_type, 64'hA5);
    check("w_stock", w_stock, 64'h1234);
    check("w_order", w_order, 64'h0123456789ABCDEF);
    check("w_price", w_price, 64'h000003E8);
    check("w_qty", w_qty, 64'h0000002A);
    check("w_pad", w_pad, 64'h1122334455);
    send_w(MW, 10);
    w_reset_n = 1'b0;
    #1;
    check("w_rst_valid", w_out_valid, 0);
    check("w_rst_type", w_type, 0);
    check("w_rst_order", w_order, 0);
    check("w_rst_pad", w_pad, 0);
    check("w_rst_in_ready", w_in_ready, 0);
    @(negedge clk);
    w_reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("w_post_rst_in_ready", w_in_ready, 1);
    check("w_post_rst_no_valid", w_out_valid, 0);
    w_out_ready = 1'b1;
    send_w(MW, 24);
    check("w2_valid", w_out_valid, 1);
    check("w2_stock", w_stock, 64'h1234);
    check("w2_order", w_order, 64'h0123456789ABCDEF);
    check("w2_qty", w_qty, 64'h0000002A);
    check("w2_pad", w_pad, 64'h1122334455);
    @(negedge clk);
    check("w2_msg_count", w_msg, 1);
    check("w2_err_count", w_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
